muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer for the single-issue MIPS core. Owns the HI/LO register pair.
- Executes the R-type functs MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO, which the main decoder only tags as register-writing with a don't-care ALU op.
- Sits beside the ALU in the execute stage and stalls the pipeline while an operation is in flight or a HI/LO access conflicts.

---
 rtl/muldiv_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO and stalls execute while busy.
// Optional `MULDIV_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier bits are zero.
module muldiv_seq #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [5:0]        funct_i,
   input  logic [DATA_W-1:0] rs_data_i,
   input  logic [DATA_W-1:0] rt_data_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic              busy_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

`ifdef MULDIV_EARLY_OUT_EN
   localparam logic EARLY_OUT = 1'b1;
`else
   localparam logic EARLY_OUT = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_next;
   logic [2*DATA_W-1:0] r_acc;
   logic [2*DATA_W-1:0] w_acc_next;
   logic [2*DATA_W-1:0] r_mcand;
   logic [2*DATA_W-1:0] w_mcand_next;
   logic [DATA_W-1:0]   r_mplier;
   logic [DATA_W-1:0]   w_mplier_next;
   logic [DATA_W-1:0]   r_hi;
   logic [DATA_W-1:0]   w_hi_next;
   logic [DATA_W-1:0]   r_lo;
   logic [DATA_W-1:0]   w_lo_next;
   logic                r_is_div;
   logic                w_is_div_next;
   logic                r_neg_a;
   logic                w_neg_a_next;
   logic                r_neg_b;
   logic                w_neg_b_next;

   // Decode of the requesting instruction
   logic              w_is_mul;
   logic              w_is_div;
   logic              w_is_md;
   logic              w_is_hilo;
   logic              w_signed;
   logic              w_rs_neg;
   logic              w_rt_neg;
   logic [DATA_W-1:0] w_rs_mag;
   logic [DATA_W-1:0] w_rt_mag;
   logic              w_idle;
   logic              w_accept;
   logic              w_write_en;

   assign w_is_mul   = (funct_i == F_MULT) || (funct_i == F_MULTU);
   assign w_is_div   = (funct_i == F_DIV)  || (funct_i == F_DIVU);
   assign w_is_md    = w_is_mul || w_is_div;
   assign w_is_hilo  = w_is_md || (funct_i == F_MFHI) || (funct_i == F_MTHI)
                       || (funct_i == F_MFLO) || (funct_i == F_MTLO);
   assign w_signed   = ~funct_i[0];
   assign w_rs_neg   = w_signed & rs_data_i[DATA_W-1];
   assign w_rt_neg   = w_signed & rt_data_i[DATA_W-1];
   assign w_rs_mag   = w_rs_neg ? -rs_data_i : rs_data_i;
   assign w_rt_mag   = w_rt_neg ? -rt_data_i : rt_data_i;
   assign w_idle     = (r_state == S_IDLE);
   assign w_write_en = w_idle & start_i & ~flush_i;
   assign w_accept   = w_write_en & w_is_md;

   // Restoring divide keeps {remainder, dividend/quotient} in r_acc; divisor sits in r_mcand low half
   logic [DATA_W:0]     w_div_shift;
   logic [DATA_W:0]     w_div_diff;
   logic                w_div_fits;
   logic [2*DATA_W-1:0] w_div_acc;

   assign w_div_shift = r_acc[2*DATA_W-1:DATA_W-1];
   assign w_div_diff  = w_div_shift - {1'b0, r_mcand[DATA_W-1:0]};
   assign w_div_fits  = ~w_div_diff[DATA_W];
   assign w_div_acc   = {(w_div_fits ? w_div_diff[DATA_W-1:0] : w_div_shift[DATA_W-1:0]),
                         r_acc[DATA_W-2:0], w_div_fits};

   logic [2*DATA_W-1:0] w_mul_acc;
   logic [DATA_W-1:0]   w_mplier_shr;

   assign w_mul_acc    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_mplier_shr = r_mplier >> 1;

   logic [2*DATA_W-1:0] w_prod_fix;
   logic [DATA_W-1:0]   w_quo_fix;
   logic [DATA_W-1:0]   w_rem_fix;

   assign w_prod_fix = r_neg_a ? -r_acc : r_acc;
   assign w_quo_fix  = r_neg_a ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
   assign w_rem_fix  = r_neg_b ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_acc_next    = r_acc;
      w_mcand_next  = r_mcand;
      w_mplier_next = r_mplier;
      w_hi_next     = r_hi;
      w_lo_next     = r_lo;
      w_is_div_next = r_is_div;
      w_neg_a_next  = r_neg_a;
      w_neg_b_next  = r_neg_b;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_is_div_next = w_is_div;
               if (w_is_div && (rt_data_i == '0)) begin
                  // Divide by zero: result is staged directly, FIX just writes it out unsigned
                  w_acc_next   = {rs_data_i, {DATA_W{1'b1}}};
                  w_neg_a_next = 1'b0;
                  w_neg_b_next = 1'b0;
                  w_state_next = S_FIX;
               end else begin
                  w_cnt_next    = CNT_W'(DATA_W - 1);
                  w_acc_next    = w_is_div ? {{DATA_W{1'b0}}, w_rs_mag} : '0;
                  w_mcand_next  = {{DATA_W{1'b0}}, (w_is_div ? w_rt_mag : w_rs_mag)};
                  w_mplier_next = w_rt_mag;
                  w_neg_a_next  = w_rs_neg ^ w_rt_neg;
                  w_neg_b_next  = w_rs_neg;
                  w_state_next  = S_CALC;
               end
            end else if (w_write_en && (funct_i == F_MTHI)) begin
               w_hi_next = rs_data_i;
            end else if (w_write_en && (funct_i == F_MTLO)) begin
               w_lo_next = rs_data_i;
            end
         end
         S_CALC: begin
            w_cnt_next = r_cnt - CNT_W'(1);
            if (r_is_div) begin
               w_acc_next = w_div_acc;
            end else begin
               w_acc_next    = w_mul_acc;
               w_mcand_next  = r_mcand << 1;
               w_mplier_next = w_mplier_shr;
            end
            if ((r_cnt == '0) || (EARLY_OUT && !r_is_div && (w_mplier_shr == '0))) begin
               w_state_next = S_FIX;
            end
         end
         S_FIX: begin
            if (r_is_div) begin
               w_hi_next = w_rem_fix;
               w_lo_next = w_quo_fix;
            end else begin
               w_hi_next = w_prod_fix[2*DATA_W-1:DATA_W];
               w_lo_next = w_prod_fix[DATA_W-1:0];
            end
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      // Flush abandons work but never cancels the HI/LO write of the FIX-exit edge
      if (flush_i) begin
         w_state_next = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_is_div <= 1'b0;
         r_neg_a  <= 1'b0;
         r_neg_b  <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_next;
         r_acc    <= w_acc_next;
         r_mcand  <= w_mcand_next;
         r_mplier <= w_mplier_next;
         r_hi     <= w_hi_next;
         r_lo     <= w_lo_next;
         r_is_div <= w_is_div_next;
         r_neg_a  <= w_neg_a_next;
         r_neg_b  <= w_neg_b_next;
      end
   end

   assign busy_o    = ~w_idle;
   assign stall_o   = busy_o & start_i & w_is_hilo;
   assign rd_data_o = (funct_i == F_MFHI) ? r_hi : r_lo;
   assign hi_o      = r_hi;
   assign lo_o      = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: random + directed stimulus; completions checked by a busy-edge monitor against a queue.
// Expected HI/LO come from plain integer arithmetic; honours `MULDIV_EARLY_OUT_EN for busy length.
module tb_muldiv_seq;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic [5:0]  funct_i = 6'h00;
   logic [31:0] rs_data_i = '0;
   logic [31:0] rt_data_i = '0;
   logic        flush_i = 1'b0;
   logic        stall_o;
   logic        busy_o;
   logic [31:0] rd_data_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   muldiv_seq #(.DATA_W(32), .CNT_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (start_i),
      .funct_i   (funct_i),
      .rs_data_i (rs_data_i),
      .rt_data_i (rt_data_i),
      .flush_i   (flush_i),
      .stall_o   (stall_o),
      .busy_o    (busy_o),
      .rd_data_o (rd_data_o),
      .hi_o      (hi_o),
      .lo_o      (lo_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic logic is_md(logic [5:0] f);
      return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
   endfunction

   function automatic int exp_len(logic [5:0] f, logic [31:0] rt);
      int len;
      len = 33;
      if (((f == F_DIV) || (f == F_DIVU)) && (rt == 0)) len = 1;
`ifdef MULDIV_EARLY_OUT_EN
      else if ((f == F_MULT) || (f == F_MULTU)) begin
         logic [31:0] mag;
         mag = ((f == F_MULT) && rt[31]) ? -rt : rt;
         len = 2;
         for (int b = 0; b < 32; b++) if (mag[b]) len = b + 2;
      end
`endif
      return len;
   endfunction

   // Reference: full-width integer arithmetic, C-style truncating signed divide
   task automatic push_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
      exp_t        e;
      longint      a;
      longint      b;
      longint      q;
      longint      r;
      logic [63:0] p;
      a = longint'($signed(rs));
      b = longint'($signed(rt));
      case (f)
         F_MULT:  begin p = a * b; m_hi = p[63:32]; m_lo = p[31:0]; end
         F_MULTU: begin p = {32'h0, rs} * {32'h0, rt}; m_hi = p[63:32]; m_lo = p[31:0]; end
         F_DIV: begin
            if (rt == 0) begin m_lo = '1; m_hi = rs; end
            else begin q = a / b; r = a % b; m_lo = q[31:0]; m_hi = r[31:0]; end
         end
         default: begin
            if (rt == 0) begin m_lo = '1; m_hi = rs; end
            else begin m_lo = rs / rt; m_hi = rs % rt; end
         end
      endcase
      e.hi  = m_hi;
      e.lo  = m_lo;
      e.len = exp_len(f, rt);
      sb_q.push_back(e);
   endtask

   task automatic push_abort(input int len);
      exp_t e;
      e.hi  = m_hi;
      e.lo  = m_lo;
      e.len = len;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy_o && n < 200) begin
         tick();
         n++;
      end
      if (busy_o) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: busy_o still 1 after %0d cycles, required 0", name, n);
      end
   endtask

   // Present one instruction in IDLE for one edge, then let it finish
   task automatic do_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
      start_i   = 1'b1;
      funct_i   = f;
      rs_data_i = rs;
      rt_data_i = rt;
      #1;
      chk("idle_stall", stall_o, 0);
      if (f == F_MFHI) chk("mfhi_rd", rd_data_o, m_hi);
      else if (f == F_MFLO) chk("mflo_rd", rd_data_o, m_lo);
      if (is_md(f)) push_op(f, rs, rt);
      else if (f == F_MTHI) m_hi = rs;
      else if (f == F_MTLO) m_lo = rs;
      tick();
      start_i = 1'b0;
      if (is_md(f)) begin
         chk("busy_after_accept", busy_o, 1);
         wait_idle("op");
      end else begin
         chk("no_busy", busy_o, 0);
         chk("hi_reg", hi_o, m_hi);
         chk("lo_reg", lo_o, m_lo);
      end
   endtask

   function automatic logic [5:0] pick_funct(int k);
      case (k)
         0: return F_MFHI;
         1: return F_MTHI;
         2: return F_MFLO;
         3: return F_MTLO;
         4: return F_MULT;
         5: return F_MULTU;
         6: return F_DIV;
         7: return F_DIVU;
         default: return 6'h05;
      endcase
   endfunction

   function automatic logic [31:0] pick_operand(int k);
      case (k)
         0: return 32'h0;
         1: return 32'($urandom_range(1, 20));
         2: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every falling busy edge is one completed (or abandoned) operation
   initial begin
      int   run;
      exp_t e;
      run = 0;
      forever begin
         @(negedge clk);
         if (busy_o) begin
            run++;
         end else if (run > 0) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: busy ended after %0d cycles, no entry queued", run);
            end else begin
               e = sb_q.pop_front();
               if (e.len >= 0) chk("busy_len", 64'(run), 64'(e.len));
               chk("sb_hi", hi_o, e.hi);
               chk("sb_lo", lo_o, e.lo);
            end
            run = 0;
         end
      end
   end

   initial begin
      int n;
      logic [5:0]  f;
      logic [31:0] a;
      logic [31:0] b;

      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_rd", rd_data_o, 0);
      chk("rst_hi", hi_o, 0);
      chk("rst_lo", lo_o, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      do_op(F_MULT, 32'hFFFF_FFFD, 32'd5);
      chk("mult_hi", hi_o, 32'hFFFF_FFFF);
      chk("mult_lo", lo_o, 32'hFFFF_FFF1);
      do_op(F_MFLO, 32'h0, 32'h0);
      chk("mflo_const", rd_data_o, 32'hFFFF_FFF1);

      do_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
      chk("div_lo", lo_o, 32'hFFFF_FFFD);
      chk("div_hi", hi_o, 32'hFFFF_FFFF);
      do_op(F_DIVU, 32'd100, 32'd7);
      chk("divu_lo", lo_o, 32'd14);
      chk("divu_hi", hi_o, 32'd2);
      do_op(F_DIVU, 32'h10, 32'h0);
      chk("div0_lo", lo_o, 32'hFFFF_FFFF);
      chk("div0_hi", hi_o, 32'h10);
      do_op(F_DIV, 32'h8000_0000, 32'h0);

      // Back-to-back MFHI behind a MULTU must stall every busy cycle
      start_i = 1'b1; funct_i = F_MULTU; rs_data_i = 32'hFFFF_FFFF; rt_data_i = 32'hFFFF_FFFF;
      push_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tick();
      funct_i = F_MFHI;
      #1;
      n = 0;
      while (stall_o && n < 100) begin
         n++;
         tick();
      end
      chk("stall_len", 64'(n), 64'(exp_len(F_MULTU, 32'hFFFF_FFFF)));
      chk("mfhi_after_stall", rd_data_o, 32'hFFFF_FFFE);
      chk("multu_lo", lo_o, 32'h0000_0001);
      start_i = 1'b0;

      do_op(F_MTHI, 32'h1234, 32'h0);
      chk("mthi_hi", hi_o, 32'h1234);

      // DIV abandoned by a flush during CALC cycle 10
      start_i = 1'b1; funct_i = F_DIV; rs_data_i = 32'd1000; rt_data_i = 32'd3;
      push_abort(10);
      tick();
      start_i = 1'b0;
      repeat (9) tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush_idle", busy_o, 0);
      chk("flush_hi", hi_o, 32'h1234);

      // Flush in IDLE blocks both an MT* write and an acceptance
      start_i = 1'b1; funct_i = F_MTHI; rs_data_i = 32'hDEAD; flush_i = 1'b1;
      tick();
      chk("flush_blocks_mt", hi_o, 32'h1234);
      funct_i = F_MULT; rt_data_i = 32'd9;
      tick();
      chk("flush_blocks_accept", busy_o, 0);
      start_i = 1'b0; flush_i = 1'b0;

      // Flush landing on the FIX-exit edge still commits the result
      start_i = 1'b1; funct_i = F_MULT; rs_data_i = 32'h0001_2345; rt_data_i = 32'hFFFF_FF00;
      push_op(F_MULT, 32'h0001_2345, 32'hFFFF_FF00);
      tick();
      start_i = 1'b0;
      n = exp_len(F_MULT, 32'hFFFF_FF00);
      repeat (n - 1) tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("fix_flush_idle", busy_o, 0);
      chk("fix_flush_hi", hi_o, m_hi);
      chk("fix_flush_lo", lo_o, m_lo);

      do_op(F_MULTU, 32'd5, 32'd3);
      chk("mul53_lo", lo_o, 32'd15);
      chk("mul53_hi", hi_o, 32'd0);

      // Requests during CALC: HI/LO-class stalls and is dropped, unknown funct is ignored
      start_i = 1'b1; funct_i = F_MULT; rs_data_i = 32'h7654_3210; rt_data_i = 32'h8000_0001;
      push_op(F_MULT, 32'h7654_3210, 32'h8000_0001);
      tick();
      funct_i = F_MTLO; rs_data_i = 32'hCAFE_F00D;
      #1;
      chk("busy_mt_stall", stall_o, 1);
      tick();
      funct_i = 6'h3F;
      #1;
      chk("busy_unknown_stall", stall_o, 0);
      start_i = 1'b0;
      wait_idle("probe");
      chk("mt_dropped_lo", lo_o, m_lo);

      for (int i = 0; i < 60; i++) begin
         f = pick_funct($urandom_range(0, 8));
         a = pick_operand($urandom_range(0, 4));
         b = pick_operand($urandom_range(0, 4));
         do_op(f, a, b);
      end

      // Asynchronous reset in the middle of a MULT
      start_i = 1'b1; funct_i = F_MULT; rs_data_i = 32'h1111_2222; rt_data_i = 32'h3333_4444;
      tick();
      start_i = 1'b0; funct_i = F_MFHI;
      repeat (5) tick();
      m_hi = '0;
      m_lo = '0;
      push_abort(-1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy_o, 0);
      chk("arst_rd", rd_data_o, 0);
      chk("arst_hi", hi_o, 0);
      chk("arst_lo", lo_o, 0);
      tick();
      rst_n = 1'b1;
      tick();
      do_op(F_DIVU, 32'hFFFF_FFFF, 32'd16);

      repeat (3) tick();
      chk("sb_empty", 64'(sb_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
